tl_ul_sram_responder: RTL and testbench

- Manager-side (responder) endpoint of the 64-bit TileLink-UL port that the client side drives.
- Accepts A-channel Get/PutFullData/PutPartialData and returns D-channel AccessAck/AccessAckData from a register-array backing store.
- Sits behind the bundle pass-through that forwards this port; serves as scratchpad and test target for the E76 eval fabric.

---
 rtl/tl_ul_pkg.sv | 43 ++++
 rtl/tl_ul_sram_responder_if.sv | 39 +++
 rtl/tl_ul_sram_store.sv | 57 +++++
 rtl/tl_ul_sram_responder.sv | 106 ++++++++++
 tb/tb_tl_ul_sram_responder.sv | 325 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tl_ul_pkg.sv
// Shared TileLink-UL definitions: opcodes, channel payload structs, data widths,
// and the alignment helper used by A-channel decode.
package tl_ul_pkg;

  localparam int unsigned TL_DATA_W = 64;
  localparam int unsigned TL_MASK_W = 8;

  localparam logic [2:0] TL_A_PUTFULL    = 3'd0;
  localparam logic [2:0] TL_A_PUTPARTIAL = 3'd1;
  localparam logic [2:0] TL_A_GET        = 3'd4;
  localparam logic [2:0] TL_D_ACK        = 3'd0;
  localparam logic [2:0] TL_D_ACKDATA    = 3'd1;

  // Address and source are carried alongside because their widths are per-instance
  typedef struct packed {
    logic [2:0]           opcode;
    logic [2:0]           param;
    logic [2:0]           size;
    logic [TL_MASK_W-1:0] mask;
    logic [TL_DATA_W-1:0] data;
    logic                 corrupt;
  } a_chan_t;

  typedef struct packed {
    logic [2:0]           opcode;
    logic [2:0]           param;
    logic [2:0]           size;
    logic                 denied;
    logic [TL_DATA_W-1:0] data;
    logic                 corrupt;
  } d_chan_t;

  // True when the low address bits are not aligned to 2^size (size <= 3)
  function automatic logic tl_misaligned(input logic [2:0] size, input logic [2:0] addr_lo);
    case (size)
      3'd0:    return 1'b0;
      3'd1:    return addr_lo[0];
      3'd2:    return |addr_lo[1:0];
      default: return |addr_lo;
    endcase
  endfunction

endpackage

// File: rtl/tl_ul_sram_responder_if.sv
// TileLink-UL A/D channel bundle; master = client, slave = responder.
interface tl_ul_sram_responder_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned SRC_W  = 3
);
  logic              a_valid;
  logic              a_ready;
  logic [2:0]        a_opcode;
  logic [2:0]        a_param;
  logic [2:0]        a_size;
  logic [SRC_W-1:0]  a_source;
  logic [ADDR_W-1:0] a_address;
  logic [7:0]        a_mask;
  logic [63:0]       a_data;
  logic              a_corrupt;
  logic              d_valid;
  logic              d_ready;
  logic [2:0]        d_opcode;
  logic [2:0]        d_param;
  logic [2:0]        d_size;
  logic [SRC_W-1:0]  d_source;
  logic              d_denied;
  logic [63:0]       d_data;
  logic              d_corrupt;

  modport master (
    output a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, a_corrupt,
    output d_ready,
    input  a_ready,
    input  d_valid, d_opcode, d_param, d_size, d_source, d_denied, d_data, d_corrupt
  );

  modport slave (
    input  a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, a_corrupt,
    input  d_ready,
    output a_ready,
    output d_valid, d_opcode, d_param, d_size, d_source, d_denied, d_data, d_corrupt
  );
endinterface

// File: rtl/tl_ul_sram_store.sv
// Byte-masked 64-bit word store: synchronous write, combinational read.
// Optional per-byte even parity under TL_SRAM_PARITY_EN.
module tl_ul_sram_store
  import tl_ul_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 6
) (
  input  logic                  clock,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] wr_idx,
  input  logic [TL_MASK_W-1:0]  wr_mask,
  input  logic [TL_DATA_W-1:0]  wr_data,
  input  logic                  wr_corrupt,
  input  logic [DEPTH_LOG2-1:0] rd_idx,
  output logic [TL_DATA_W-1:0]  rd_data,
  output logic                  rd_corrupt_c
);
  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  logic [TL_DATA_W-1:0] mem [DEPTH];

  // Storage is intentionally not reset
  always_ff @(posedge clock) begin
    if (we) begin
      for (int b = 0; b < int'(TL_MASK_W); b++) begin
        if (wr_mask[b]) mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  assign rd_data = mem[rd_idx];

`ifdef TL_SRAM_PARITY_EN
  logic [TL_MASK_W-1:0] par [DEPTH];

  // Stored bit makes each byte+parity even; a corrupt write stores the wrong sense
  always_ff @(posedge clock) begin
    if (we) begin
      for (int b = 0; b < int'(TL_MASK_W); b++) begin
        if (wr_mask[b]) par[wr_idx][b] <= (^wr_data[8*b +: 8]) ^ wr_corrupt;
      end
    end
  end

  always_comb begin
    rd_corrupt_c = 1'b0;
    for (int b = 0; b < int'(TL_MASK_W); b++) begin
      if ((^rd_data[8*b +: 8]) != par[rd_idx][b]) rd_corrupt_c = 1'b1;
    end
  end
`else
  logic unused_wr_corrupt;
  assign unused_wr_corrupt = wr_corrupt;
  assign rd_corrupt_c      = 1'b0;
`endif

endmodule

// File: rtl/tl_ul_sram_responder.sv
// TileLink-UL responder backed by a register-array scratchpad; one response register,
// latency 1, full throughput. Optional parity: define TL_SRAM_PARITY_EN.
module tl_ul_sram_responder
  import tl_ul_pkg::*;
#(
  parameter int unsigned       ADDR_W     = 32,
  parameter int unsigned       SRC_W      = 3,
  parameter int unsigned       DEPTH_LOG2 = 6,
  parameter logic [ADDR_W-1:0] BASE       = '0
) (
  input  logic                  clock,
  input  logic                  reset,
  tl_ul_sram_responder_if.slave tl
);
  localparam int unsigned       SPAN_W = ADDR_W + 1;
  localparam logic [SPAN_W-1:0] SPAN   = SPAN_W'(8) << DEPTH_LOG2;

  a_chan_t               a_req;
  d_chan_t               d_nxt;
  d_chan_t               d_q;
  logic [SRC_W-1:0]      d_source_q;
  logic                  d_valid_q;
  logic [ADDR_W-1:0]     offset;
  logic [DEPTH_LOG2-1:0] idx;
  logic                  in_range;
  logic                  is_get;
  logic                  is_put;
  logic                  err;
  logic                  a_ready_c;
  logic                  fire;
  logic                  we;
  logic [TL_DATA_W-1:0]  rd_data;
  logic                  rd_corrupt_c;

  assign a_req = '{opcode:  tl.a_opcode,
                   param:   tl.a_param,
                   size:    tl.a_size,
                   mask:    tl.a_mask,
                   data:    tl.a_data,
                   corrupt: tl.a_corrupt};

  // Request decode and error classification
  assign offset   = tl.a_address - BASE;
  assign idx      = offset[DEPTH_LOG2+2:3];
  assign in_range = (tl.a_address >= BASE) && ({1'b0, offset} < SPAN);
  assign is_get   = (a_req.opcode == TL_A_GET);
  assign is_put   = (a_req.opcode == TL_A_PUTFULL) || (a_req.opcode == TL_A_PUTPARTIAL);
  assign err      = !in_range || (a_req.size > 3'd3) ||
                    tl_misaligned(a_req.size, tl.a_address[2:0]) ||
                    !(is_get || is_put) || (a_req.param != 3'd0);

  assign a_ready_c = !d_valid_q || tl.d_ready;
  assign fire      = tl.a_valid && a_ready_c;
  assign we        = fire && is_put && !err;

  tl_ul_sram_store #(.DEPTH_LOG2(DEPTH_LOG2)) u_store (
    .clock        (clock),
    .we           (we),
    .wr_idx       (idx),
    .wr_mask      (a_req.mask),
    .wr_data      (a_req.data),
    .wr_corrupt   (a_req.corrupt),
    .rd_idx       (idx),
    .rd_data      (rd_data),
    .rd_corrupt_c (rd_corrupt_c)
  );

  // Response payload for a request firing this cycle
  always_comb begin
    d_nxt        = '0;
    d_nxt.size   = a_req.size;
    d_nxt.opcode = is_get ? TL_D_ACKDATA : TL_D_ACK;
    if (err) begin
      d_nxt.denied = 1'b1;
    end else if (is_get) begin
      d_nxt.data    = rd_data;
      d_nxt.corrupt = rd_corrupt_c;
    end
  end

  // Response register: load on fire, drop when consumed, otherwise hold
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      d_valid_q  <= 1'b0;
      d_q        <= '0;
      d_source_q <= '0;
    end else if (fire) begin
      d_valid_q  <= 1'b1;
      d_q        <= d_nxt;
      d_source_q <= tl.a_source;
    end else if (tl.d_ready) begin
      d_valid_q  <= 1'b0;
    end
  end

  assign tl.a_ready   = a_ready_c;
  assign tl.d_valid   = d_valid_q;
  assign tl.d_opcode  = d_q.opcode;
  assign tl.d_param   = d_q.param;
  assign tl.d_size    = d_q.size;
  assign tl.d_source  = d_source_q;
  assign tl.d_denied  = d_q.denied;
  assign tl.d_data    = d_q.data;
  assign tl.d_corrupt = d_q.corrupt;

endmodule

// File: tb/tb_tl_ul_sram_responder.sv
// Bench for tl_ul_sram_responder: directed vector table, back-pressure and reset
// sequences, then randomized traffic against a word/byte-level memory model.
module tb_tl_ul_sram_responder;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned SRC_W  = 3;
  localparam int unsigned WORDS  = 64;
  localparam logic [31:0] BASE   = 32'h0;

  typedef struct {
    logic [2:0]  op;
    logic [2:0]  param;
    logic [2:0]  size;
    logic [2:0]  src;
    logic [31:0] addr;
    logic [7:0]  mask;
    logic [63:0] data;
    logic        corrupt;
  } req_t;

  typedef struct {
    logic [2:0]  opcode;
    logic        denied;
    logic [2:0]  src;
    logic [2:0]  size;
    logic        chk_data;
    logic [63:0] data;
    logic        corrupt;
  } rsp_t;

  typedef struct {
    req_t        req;
    logic [2:0]  e_op;
    logic        e_den;
    logic        e_chk;
    logic [63:0] e_data;
    logic        e_cor;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  tl_ul_sram_responder_if #(.ADDR_W(ADDR_W), .SRC_W(SRC_W)) bus ();

  tl_ul_sram_responder #(.ADDR_W(ADDR_W), .SRC_W(SRC_W), .DEPTH_LOG2(6), .BASE(BASE)) dut (
    .clock (clk),
    .reset (rst),
    .tl    (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  logic [63:0] mmem [WORDS];
`ifdef TL_SRAM_PARITY_EN
  logic [7:0]  mbad [WORDS];
`endif
  rsp_t exp_q[$];
  vec_t vecs[$];
  req_t cur;
  bit   a_hold = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic req_t mk(input logic [2:0] op, input logic [2:0] param, input logic [2:0] size,
                              input logic [2:0] src, input logic [31:0] addr, input logic [7:0] mask,
                              input logic [63:0] data, input logic cor);
    req_t r;
    r.op = op; r.param = param; r.size = size; r.src = src;
    r.addr = addr; r.mask = mask; r.data = data; r.corrupt = cor;
    return r;
  endfunction

  task automatic drive(input req_t r);
    bus.a_opcode  = r.op;
    bus.a_param   = r.param;
    bus.a_size    = r.size;
    bus.a_source  = r.src;
    bus.a_address = r.addr;
    bus.a_mask    = r.mask;
    bus.a_data    = r.data;
    bus.a_corrupt = r.corrupt;
  endtask

  // Reference model: decides the response from the protocol rules and updates memory
  function automatic rsp_t model(input req_t r);
    rsp_t e;
    bit   den;
    int   idx;
    den = (r.addr < BASE) || ((r.addr - BASE) >= 32'(WORDS * 8)) || (r.size > 3'd3) ||
          !(r.op inside {3'd0, 3'd1, 3'd4}) || (r.param != 3'd0);
    if (!den && ((r.addr % (32'd1 << r.size)) != 0)) den = 1;
    idx        = int'((r.addr - BASE) / 8) % int'(WORDS);
    e.opcode   = (r.op == 3'd4) ? 3'd1 : 3'd0;
    e.denied   = den;
    e.src      = r.src;
    e.size     = r.size;
    e.chk_data = 1'b1;
    e.data     = '0;
    e.corrupt  = 1'b0;
    if (!den && r.op == 3'd4) begin
      e.data = mmem[idx];
`ifdef TL_SRAM_PARITY_EN
      e.corrupt = |mbad[idx];
`endif
    end else if (!den) begin
      e.chk_data = 1'b0;
      for (int b = 0; b < 8; b++) begin
        if (r.mask[b]) begin
          mmem[idx][8*b +: 8] = r.data[8*b +: 8];
`ifdef TL_SRAM_PARITY_EN
          mbad[idx][b] = r.corrupt;
`endif
        end
      end
    end
    return e;
  endfunction

  task automatic cmp_rsp(input string tag, input rsp_t e);
    check({tag, ".opcode"}, 64'(bus.d_opcode), 64'(e.opcode));
    check({tag, ".denied"}, 64'(bus.d_denied), 64'(e.denied));
    check({tag, ".source"}, 64'(bus.d_source), 64'(e.src));
    check({tag, ".size"}, 64'(bus.d_size), 64'(e.size));
    check({tag, ".param"}, 64'(bus.d_param), 64'd0);
    check({tag, ".corrupt"}, 64'(bus.d_corrupt), 64'(e.corrupt));
    if (e.chk_data) check({tag, ".data"}, bus.d_data, e.data);
  endtask

  // One clock of model-checked traffic; holds an unaccepted request stable
  task automatic step(input req_t r, input bit v, input bit dr, output bit fired);
    @(negedge clk);
    if (!a_hold) begin
      cur = r;
      drive(r);
      bus.a_valid = v;
    end
    bus.d_ready = dr;
    #1;
    check("a_ready_rule", 64'(bus.a_ready), 64'(!bus.d_valid || bus.d_ready));
    check("d_valid_pending", 64'(bus.d_valid), 64'(exp_q.size() != 0));
    if (bus.d_valid && exp_q.size() != 0) begin
      cmp_rsp("rsp", exp_q[0]);
      if (bus.d_ready) void'(exp_q.pop_front());
    end
    fired = bus.a_valid && bus.a_ready;
    if (fired) begin
      exp_q.push_back(model(cur));
      a_hold = 0;
    end else begin
      a_hold = bus.a_valid;
    end
  endtask

  task automatic apply_vec(input int i, input vec_t v);
    rsp_t e;
    @(negedge clk);
    drive(v.req);
    bus.a_valid = 1'b1;
    bus.d_ready = 1'b1;
    #1;
    check($sformatf("vec%0d.a_ready", i), 64'(bus.a_ready), 64'd1);
    @(negedge clk);
    bus.a_valid = 1'b0;
    check($sformatf("vec%0d.d_valid", i), 64'(bus.d_valid), 64'd1);
    e.opcode = v.e_op; e.denied = v.e_den; e.src = v.req.src; e.size = v.req.size;
    e.chk_data = v.e_chk; e.data = v.e_data; e.corrupt = v.e_cor;
    cmp_rsp($sformatf("vec%0d", i), e);
  endtask

  function automatic req_t rand_req();
    req_t r;
    int   k;
    k = int'($urandom_range(0, 9));
    r.op      = (k < 4) ? 3'd4 : (k < 7) ? 3'd0 : (k < 9) ? 3'd1 : 3'($urandom_range(0, 7));
    r.param   = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
    r.size    = ($urandom_range(0, 7) != 0) ? 3'd3 : 3'($urandom_range(0, 7));
    r.src     = 3'($urandom);
    r.addr    = $urandom_range(0, 32'h27F);
    if (r.size <= 3'd3 && $urandom_range(0, 3) != 0) r.addr = r.addr & ~((32'd1 << r.size) - 32'd1);
    r.mask    = 8'($urandom);
    r.data    = {$urandom, $urandom};
    r.corrupt = ($urandom_range(0, 7) == 0);
    return r;
  endfunction

  initial begin
    req_t r;
    bit   fired;
    logic [63:0] w0, w1;

    bus.a_valid = 0; bus.d_ready = 1;
    drive(mk(3'd0, 3'd0, 3'd0, 3'd0, 32'd0, 8'd0, 64'd0, 1'b0));

    // Directed table: {request, expected opcode, denied, data-checked, data, corrupt}
    vecs.push_back('{mk(3'd0, 3'd0, 3'd3, 3'd5, 32'h08, 8'hFF, 64'h1122334455667788, 1'b0), 3'd0, 1'b0, 1'b0, 64'd0, 1'b0});
    vecs.push_back('{mk(3'd4, 3'd0, 3'd3, 3'd1, 32'h08, 8'hFF, 64'd0, 1'b0), 3'd1, 1'b0, 1'b1, 64'h1122334455667788, 1'b0});
    vecs.push_back('{mk(3'd1, 3'd0, 3'd3, 3'd2, 32'h08, 8'h0F, 64'hAAAAAAAAAAAAAAAA, 1'b0), 3'd0, 1'b0, 1'b0, 64'd0, 1'b0});
    vecs.push_back('{mk(3'd4, 3'd0, 3'd3, 3'd6, 32'h08, 8'h00, 64'd0, 1'b0), 3'd1, 1'b0, 1'b1, 64'h11223344AAAAAAAA, 1'b0});
    vecs.push_back('{mk(3'd4, 3'd0, 3'd3, 3'd0, 32'h200, 8'hFF, 64'd0, 1'b0), 3'd1, 1'b1, 1'b1, 64'd0, 1'b0});
    vecs.push_back('{mk(3'd4, 3'd0, 3'd2, 3'd3, 32'h02, 8'hFF, 64'd0, 1'b0), 3'd1, 1'b1, 1'b1, 64'd0, 1'b0});
    vecs.push_back('{mk(3'd2, 3'd0, 3'd3, 3'd4, 32'h10, 8'hFF, 64'd0, 1'b0), 3'd0, 1'b1, 1'b1, 64'd0, 1'b0});
    vecs.push_back('{mk(3'd4, 3'd0, 3'd4, 3'd1, 32'h00, 8'hFF, 64'd0, 1'b0), 3'd1, 1'b1, 1'b1, 64'd0, 1'b0});
    vecs.push_back('{mk(3'd0, 3'd1, 3'd3, 3'd2, 32'h00, 8'hFF, 64'd5, 1'b0), 3'd0, 1'b1, 1'b1, 64'd0, 1'b0});
    vecs.push_back('{mk(3'd0, 3'd0, 3'd3, 3'd7, 32'h00, 8'hFF, 64'hC0FFEE0012345678, 1'b0), 3'd0, 1'b0, 1'b0, 64'd0, 1'b0});
    vecs.push_back('{mk(3'd0, 3'd0, 3'd3, 3'd6, 32'h200, 8'hFF, 64'hDEADBEEFDEADBEEF, 1'b0), 3'd0, 1'b1, 1'b1, 64'd0, 1'b0});
    vecs.push_back('{mk(3'd0, 3'd0, 3'd3, 3'd5, 32'h04, 8'hFF, 64'h0BAD0BAD0BAD0BAD, 1'b0), 3'd0, 1'b1, 1'b1, 64'd0, 1'b0});
    vecs.push_back('{mk(3'd4, 3'd0, 3'd3, 3'd4, 32'h00, 8'h00, 64'd0, 1'b0), 3'd1, 1'b0, 1'b1, 64'hC0FFEE0012345678, 1'b0});
    vecs.push_back('{mk(3'd0, 3'd0, 3'd3, 3'd3, 32'h1F8, 8'hFF, 64'h0123456789ABCDEF, 1'b0), 3'd0, 1'b0, 1'b0, 64'd0, 1'b0});
    vecs.push_back('{mk(3'd4, 3'd0, 3'd3, 3'd7, 32'h1F8, 8'h00, 64'd0, 1'b0), 3'd1, 1'b0, 1'b1, 64'h0123456789ABCDEF, 1'b0});
    vecs.push_back('{mk(3'd4, 3'd0, 3'd2, 3'd2, 32'h0C, 8'h00, 64'd0, 1'b0), 3'd1, 1'b0, 1'b1, 64'h11223344AAAAAAAA, 1'b0});
    vecs.push_back('{mk(3'd4, 3'd0, 3'd0, 3'd1, 32'h0B, 8'h00, 64'd0, 1'b0), 3'd1, 1'b0, 1'b1, 64'h11223344AAAAAAAA, 1'b0});
    vecs.push_back('{mk(3'd4, 3'd0, 3'd3, 3'd0, 32'h1FC, 8'h00, 64'd0, 1'b0), 3'd1, 1'b1, 1'b1, 64'd0, 1'b0});
`ifdef TL_SRAM_PARITY_EN
    vecs.push_back('{mk(3'd0, 3'd0, 3'd3, 3'd1, 32'h10, 8'hFF, 64'd0, 1'b0), 3'd0, 1'b0, 1'b0, 64'd0, 1'b0});
    vecs.push_back('{mk(3'd1, 3'd0, 3'd3, 3'd2, 32'h10, 8'h01, 64'h5A, 1'b1), 3'd0, 1'b0, 1'b0, 64'd0, 1'b0});
    vecs.push_back('{mk(3'd4, 3'd0, 3'd3, 3'd3, 32'h10, 8'h00, 64'd0, 1'b0), 3'd1, 1'b0, 1'b1, 64'h5A, 1'b1});
    vecs.push_back('{mk(3'd0, 3'd0, 3'd3, 3'd4, 32'h10, 8'hFF, 64'h77, 1'b0), 3'd0, 1'b0, 1'b0, 64'd0, 1'b0});
    vecs.push_back('{mk(3'd4, 3'd0, 3'd3, 3'd5, 32'h10, 8'h00, 64'd0, 1'b0), 3'd1, 1'b0, 1'b1, 64'h77, 1'b0});
`else
    vecs.push_back('{mk(3'd0, 3'd0, 3'd3, 3'd1, 32'h10, 8'hFF, 64'h5A, 1'b1), 3'd0, 1'b0, 1'b0, 64'd0, 1'b0});
    vecs.push_back('{mk(3'd4, 3'd0, 3'd3, 3'd3, 32'h10, 8'h00, 64'd0, 1'b0), 3'd1, 1'b0, 1'b1, 64'h5A, 1'b0});
`endif

    // Reset state
    repeat (3) @(negedge clk);
    check("reset.d_valid", 64'(bus.d_valid), 64'd0);
    check("reset.d_opcode", 64'(bus.d_opcode), 64'd0);
    check("reset.d_data", bus.d_data, 64'd0);
    check("reset.d_denied", 64'(bus.d_denied), 64'd0);
    check("reset.d_source", 64'(bus.d_source), 64'd0);
    rst = 0;
    @(negedge clk);
    check("idle.a_ready", 64'(bus.a_ready), 64'd1);

    foreach (vecs[i]) apply_vec(i, vecs[i]);
    w0 = 64'hC0FFEE0012345678;
    w1 = 64'h11223344AAAAAAAA;

    // Back-pressure: response held while d_ready=0, then back-to-back replacement
    @(negedge clk);
    drive(mk(3'd4, 3'd0, 3'd3, 3'd3, 32'h08, 8'h00, 64'd0, 1'b0));
    bus.a_valid = 1; bus.d_ready = 0;
    @(negedge clk);
    drive(mk(3'd4, 3'd0, 3'd3, 3'd4, 32'h00, 8'h00, 64'd0, 1'b0));
    for (int c = 0; c < 3; c++) begin
      #1;
      check("bp.a_ready", 64'(bus.a_ready), 64'd0);
      check("bp.d_valid", 64'(bus.d_valid), 64'd1);
      check("bp.d_data", bus.d_data, w1);
      check("bp.d_source", 64'(bus.d_source), 64'd3);
      check("bp.d_opcode", 64'(bus.d_opcode), 64'd1);
      @(negedge clk);
    end
    bus.d_ready = 1;
    #1;
    check("bp.release_a_ready", 64'(bus.a_ready), 64'd1);
    @(negedge clk);
    bus.a_valid = 0;
    check("bp.next_valid", 64'(bus.d_valid), 64'd1);
    check("bp.next_source", 64'(bus.d_source), 64'd4);
    check("bp.next_data", bus.d_data, w0);
    @(negedge clk);
    check("bp.drained", 64'(bus.d_valid), 64'd0);

    // Fill the whole store through the model so later reads are fully defined
    for (int i = 0; i < int'(WORDS); i++) begin
      step(mk(3'd0, 3'd0, 3'd3, 3'(i), 32'(i * 8), 8'hFF, {$urandom, $urandom}, 1'b0), 1'b1, 1'b1, fired);
    end

    // Alternating Put/Get stream at full rate
    for (int i = 0; i < 16; i++) begin
      if (i % 2 == 0)
        r = mk(3'd1, 3'd0, 3'd3, 3'(i), 32'(8 * (20 + i / 2)), 8'($urandom), {$urandom, $urandom}, 1'b0);
      else
        r = mk(3'd4, 3'd0, 3'd3, 3'(i), 32'(8 * (20 + i / 2)), 8'h00, 64'd0, 1'b0);
      step(r, 1'b1, 1'b1, fired);
      check("stream.fire", 64'(fired), 64'd1);
    end

    // Randomized traffic with random valid/ready
    for (int i = 0; i < 600; i++) begin
      step(rand_req(), $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, fired);
    end
    for (int i = 0; i < 4; i++) begin
      step(rand_req(), 1'b0, 1'b1, fired);
    end
    check("final.queue_empty", 64'(exp_q.size()), 64'd0);

    // Reset with a response pending drops it
    @(negedge clk);
    drive(mk(3'd4, 3'd0, 3'd3, 3'd6, 32'h08, 8'h00, 64'd0, 1'b0));
    bus.a_valid = 1; bus.d_ready = 0;
    @(negedge clk);
    bus.a_valid = 0;
    check("midrst.before", 64'(bus.d_valid), 64'd1);
    #1 rst = 1;
    #1;
    check("midrst.d_valid", 64'(bus.d_valid), 64'd0);
    check("midrst.d_source", 64'(bus.d_source), 64'd0);
    check("midrst.d_data", bus.d_data, 64'd0);
    @(negedge clk);
    rst = 0;
    bus.d_ready = 1;
    @(negedge clk);
    check("midrst.after", 64'(bus.d_valid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
